// File: rtl/bist_pkg.sv
// bist_pkg: shared March C- encodings and per-element tables for the BIST controller.
package bist_pkg;
  typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;
  typedef enum logic {OP_R, OP_W} op_t;
  localparam logic [2:0] E0 = 3'd0;
  localparam logic [2:0] E1 = 3'd1;
  localparam logic [2:0] E2 = 3'd2;
  localparam logic [2:0] E3 = 3'd3;
  localparam logic [2:0] E4 = 3'd4;
  localparam logic [2:0] E5 = 3'd5;
  // Bit e of each table describes element e.
  localparam logic [7:0] ELEM_DOWN = 8'b0001_1000;
  localparam logic [7:0] ELEM_TWO  = 8'b0001_1110;
  localparam logic [7:0] RD_BG     = 8'b0001_0100;
  localparam logic [7:0] WR_BG     = 8'b0000_1010;
  function automatic op_t elem_op(input logic [2:0] e, input logic ph);
    return ELEM_TWO[e] ? (ph ? OP_W : OP_R) : (e == E0 ? OP_W : OP_R);
  endfunction
endpackage

// File: rtl/bist_addr_gen.sv
// bist_addr_gen: loadable up/down address counter; direction is latched at load time.
module bist_addr_gen #(
  parameter int ADDR_SIZE = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 load,
  input  logic                 down,
  input  logic                 en,
  output logic [ADDR_SIZE-1:0] addr,
  output logic                 last
);
  logic dir;
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      addr <= '0;
      dir  <= 1'b0;
    end else if (load) begin
      addr <= down ? '1 : '0;
      dir  <= down;
    end else if (en) begin
      addr <= dir ? addr - 1'b1 : addr + 1'b1;
    end
  assign last = dir ? (addr == '0) : (addr == '1);
endmodule

// File: rtl/bist_march_ctrl.sv
// bist_march_ctrl: March C- sequencer with read-latency-aligned compare and first-fail logger.
module bist_march_ctrl
  import bist_pkg::*;
#(
  parameter int DATA_SIZE = 8,
  parameter int ADDR_SIZE = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  output logic [ADDR_SIZE-1:0] mem_addr,
  output logic                 mem_wr,
  output logic                 mem_rd,
  output logic [DATA_SIZE-1:0] data_wr,
  output logic [DATA_SIZE-1:0] data_et,
  output logic                 read_en,
  input  logic                 error,
  output logic                 busy,
  output logic                 done,
  output logic                 fail,
  output logic [ADDR_SIZE-1:0] fail_addr,
  output logic [2:0]           fail_elem,
  output logic [7:0]           fail_count
);
  state_t state, state_n;
  logic [2:0] elem, elem_n;
  logic ph, ph_n;
  logic go, run, op_last, load, load_down, step, last;
  logic exp_q;
  logic [ADDR_SIZE-1:0] addr, pa_q;
  logic [2:0] pe_q;
  op_t op;

  bist_addr_gen #(.ADDR_SIZE(ADDR_SIZE)) u_addr (
    .clk(clk), .rst(rst), .load(load), .down(load_down), .en(step),
    .addr(addr), .last(last)
  );

  assign run     = state == RUN;
  assign go      = (state == IDLE || state == DONE) && start;
  assign op      = elem_op(elem, ph);
  assign op_last = !ELEM_TWO[elem] || ph;

  always_comb begin
    state_n   = state;
    elem_n    = elem;
    ph_n      = ph;
    load      = go;
    load_down = 1'b0;
    step      = 1'b0;
    if (go) begin
      state_n = RUN;
      elem_n  = E0;
      ph_n    = 1'b0;
    end else if (run) begin
      ph_n = ELEM_TWO[elem] && !ph;
      if (op_last && last) begin
        if (elem == E5) state_n = DRAIN;
        else begin
          elem_n    = elem + 3'd1;
          load      = 1'b1;
          load_down = ELEM_DOWN[elem_n];
        end
      end else step = op_last;
    end else if (state == DRAIN) begin
      state_n = DONE;
    end
  end

  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state <= IDLE;
      elem  <= E0;
      ph    <= 1'b0;
    end else begin
      state <= state_n;
      elem  <= elem_n;
      ph    <= ph_n;
    end

  assign mem_addr = addr;
  assign mem_wr   = run && op == OP_W;
  assign mem_rd   = run && op == OP_R;
  assign data_wr  = {DATA_SIZE{mem_wr && WR_BG[elem]}};
  assign busy     = run || state == DRAIN;
  assign done     = state == DONE;

  // Expected data and location ride one cycle behind the read strobe.
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      read_en <= 1'b0;
      exp_q   <= 1'b0;
      pa_q    <= '0;
      pe_q    <= '0;
    end else begin
      read_en <= mem_rd;
      if (mem_rd) begin
        exp_q <= RD_BG[elem];
        pa_q  <= addr;
        pe_q  <= elem;
      end
    end
  assign data_et = {DATA_SIZE{exp_q}};

  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      fail       <= 1'b0;
      fail_addr  <= '0;
      fail_elem  <= '0;
      fail_count <= '0;
    end else if (go) begin
      fail       <= 1'b0;
      fail_addr  <= '0;
      fail_elem  <= '0;
      fail_count <= '0;
    end else if (read_en && error) begin
      fail_count <= (fail_count == 8'hff) ? fail_count : fail_count + 8'd1;
      if (!fail) begin
        fail      <= 1'b1;
        fail_addr <= pa_q;
        fail_elem <= pe_q;
      end
    end
endmodule

// File: tb/tb_bist_march_ctrl.sv
// tb_bist_march_ctrl: March C- controller bench with faulty-memory model and op scoreboard.
module tb_bist_march_ctrl;
  localparam int N = 16;
  logic clk = 1'b0, rst = 1'b1, start = 1'b0, error;
  logic [3:0] mem_addr, fail_addr;
  logic mem_wr, mem_rd, read_en, busy, done, fail;
  logic [7:0] data_wr, data_et, fail_count, rdata;
  logic [2:0] fail_elem;

  bist_march_ctrl #(.DATA_SIZE(8), .ADDR_SIZE(4)) dut (
    .clk(clk), .rst(rst), .start(start), .mem_addr(mem_addr), .mem_wr(mem_wr),
    .mem_rd(mem_rd), .data_wr(data_wr), .data_et(data_et), .read_en(read_en),
    .error(error), .busy(busy), .done(done), .fail(fail), .fail_addr(fail_addr),
    .fail_elem(fail_elem), .fail_count(fail_count)
  );

  always #5 clk = ~clk;

  typedef struct {
    int kind; int fa; int fb; bit glitch; bit mid_start;
    bit exp_fail; int exp_fa; int exp_fe; int exp_cnt;
  } tc_t;
  typedef struct { bit wr; bit rd; logic [3:0] a; logic bg; } op_s;

  int compared = 0, mismatched = 0;
  int fkind = 0, faddr = 0, fbit = 0;
  bit glitch = 1'b0;
  logic [7:0] mem [N];
  op_s q[$];
  logic exp_q[$];
  tc_t tcs[6];

  function automatic logic [7:0] rd_model(input int a);
    logic [7:0] v;
    v = mem[a];
    if (fkind == 3) v = 8'h00;
    if (fkind == 1 && a == faddr) v[fbit] = 1'b1;
    if (fkind == 2 && a == faddr) v[fbit] = 1'b0;
    return v;
  endfunction

  always @(posedge clk) begin
    if (mem_wr) mem[mem_addr] <= data_wr;
    if (mem_rd) rdata <= rd_model(int'(mem_addr));
  end
  assign error = (read_en && rdata != data_et) || (glitch && !read_en);

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic build_ops();
    int down[6] = '{0, 0, 0, 1, 1, 0};
    int two[6]  = '{0, 1, 1, 1, 1, 0};
    int rbg[6]  = '{0, 0, 1, 0, 1, 0};
    int wbg[6]  = '{0, 1, 0, 1, 0, 0};
    logic [3:0] a;
    q.delete();
    exp_q.delete();
    for (int e = 0; e < 6; e++)
      for (int i = 0; i < N; i++) begin
        a = 4'(down[e] != 0 ? N - 1 - i : i);
        if (two[e] != 0) begin
          q.push_back('{1'b0, 1'b1, a, rbg[e] != 0});
          q.push_back('{1'b1, 1'b0, a, wbg[e] != 0});
        end else if (e == 0) q.push_back('{1'b1, 1'b0, a, 1'b0});
        else q.push_back('{1'b0, 1'b1, a, 1'b0});
      end
  endtask

  task automatic step_check(inout bit prev_rd);
    op_s o;
    o = q.pop_front();
    chk("op", {mem_wr, mem_rd, busy, mem_addr, data_wr},
        {o.wr, o.rd, 1'b1, o.a, {8{o.wr & o.bg}}});
    chk("read_en", read_en, prev_rd);
    if (prev_rd) chk("data_et", data_et, {8{exp_q.pop_front()}});
    if (o.rd) exp_q.push_back(o.bg);
    prev_rd = o.rd;
  endtask

  task automatic run_test(input tc_t t, input bit hold);
    bit prev_rd = 1'b0;
    fkind = t.kind; faddr = t.fa; fbit = t.fb; glitch = t.glitch;
    build_ops();
    @(negedge clk) start = 1'b1;
    @(posedge clk);
    @(negedge clk) if (!hold) start = 1'b0;
    for (int c = 0; c < 10 * N; c++) begin
      step_check(prev_rd);
      if (t.mid_start && c == 70) start = 1'b1;
      if (t.mid_start && c == 71) start = 1'b0;
      @(negedge clk);
    end
    chk("drain", {busy, done, mem_wr, mem_rd, read_en}, 5'b10001);
    chk("drain_et", data_et, {8{exp_q.pop_front()}});
    @(negedge clk);
    chk("done", {busy, done}, 2'b01);
    chk("fail", fail, t.exp_fail);
    chk("fail_addr", fail_addr, t.exp_fa);
    chk("fail_elem", fail_elem, t.exp_fe);
    chk("fail_count", fail_count, t.exp_cnt);
    if (hold) begin
      @(negedge clk);
      chk("restart", {busy, done, mem_wr, mem_addr, fail, fail_count}, {3'b101, 4'd0, 1'b0, 8'd0});
      start = 1'b0;
      #1 rst = 1'b1;
      @(negedge clk) rst = 1'b0;
    end else begin
      repeat (3) @(negedge clk);
      chk("done_hold", {busy, done, fail_count}, {2'b01, 8'(t.exp_cnt)});
    end
    glitch = 1'b0;
  endtask

  initial begin
    for (int i = 0; i < N; i++) mem[i] = 8'($urandom);
    tcs[0] = '{0, 0, 0, 1'b1, 1'b1, 1'b0, 0, 0, 0};
    tcs[1] = '{1, 5, 3, 1'b0, 1'b0, 1'b1, 5, 1, 3};
    tcs[2] = '{2, 15, 0, 1'b0, 1'b0, 1'b1, 15, 2, 2};
    tcs[3] = '{3, 0, 0, 1'b0, 1'b0, 1'b1, 0, 2, 32};
    tcs[4] = '{1, 15, 7, 1'b0, 1'b0, 1'b1, 15, 1, 3};
    tcs[5] = '{2, 0, 7, 1'b0, 1'b0, 1'b1, 0, 2, 2};
    #2;
    chk("reset", {mem_addr, mem_wr, mem_rd, data_wr, data_et, read_en, busy, done,
                  fail, fail_addr, fail_elem, fail_count}, '0);
    @(negedge clk) rst = 1'b0;
    repeat (2) @(negedge clk);
    chk("idle", {busy, done, mem_wr, mem_rd}, 4'b0000);
    foreach (tcs[i]) run_test(tcs[i], 1'b0);
    fkind = 1; faddr = 5; fbit = 3;
    @(negedge clk) start = 1'b1;
    @(negedge clk) start = 1'b0;
    repeat (49) @(negedge clk);
    chk("pre_rst", {busy, fail, fail_count}, {2'b11, 8'd1});
    #2 rst = 1'b1;
    #1;
    chk("async_rst", {mem_addr, mem_wr, mem_rd, data_wr, data_et, read_en, busy, done,
                      fail, fail_addr, fail_elem, fail_count}, '0);
    @(negedge clk) rst = 1'b0;
    @(negedge clk);
    chk("rst_idle", {busy, done}, 2'b00);
    run_test('{0, 0, 0, 1'b0, 1'b0, 1'b0, 0, 0, 0}, 1'b0);
    run_test('{0, 0, 0, 1'b0, 1'b0, 1'b0, 0, 0, 0}, 1'b1);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule
